shift_add_multiplier: RTL and testbench

//  Sequential unsigned shift-and-add multiplier. It is the companion of the

---
 rtl/shift_add_multiplier_if.sv | 30 +++
 rtl/shift_add_multiplier.sv | 126 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake bundle shared by the shift-and-add multiplier and its requester.
// The requester drives the operands and start; the multiplier returns status and the product.
interface shift_add_multiplier_if #(
    parameter int SIZE = 8
);
    logic                start;
    logic [SIZE-1:0]     multiplicand;
    logic [SIZE-1:0]     multiplier;
    logic                busy;
    logic                done;
    logic [2*SIZE-1:0]   product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per cycle,
// with an early exit when either operand is zero.
module shift_add_multiplier #(
    parameter int SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_add_multiplier_if.slave bus
);

    localparam int              CNT_W    = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_FOR_START = 2'd0,
        CHECK_ZERO     = 2'd1,
        ADD_SHIFT      = 2'd2,
        DONE           = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [SIZE-1:0]     r_multiplicand;
    logic [SIZE-1:0]     r_multiplier;
    logic [SIZE-1:0]     r_accHi;
    logic [SIZE-1:0]     r_accLo;
    logic [CNT_W-1:0]    r_count;
    logic [2*SIZE-1:0]   r_product;

    logic                w_zeroOperand;
    logic                w_lastStep;
    logic [SIZE:0]       w_sum;
    logic [SIZE-1:0]     w_stepHi;
    logic [SIZE-1:0]     w_stepLo;

    assign w_zeroOperand = (r_multiplicand == '0) || (r_multiplier == '0);
    assign w_lastStep    = (r_count == CNT_ONE);

    // One add-then-shift step: the carry out of the add becomes the new MSB of accHi.
    always_comb begin
        w_sum    = {1'b0, r_accHi};
        if (r_accLo[0]) begin
            w_sum = {1'b0, r_accHi} + {1'b0, r_multiplicand};
        end
        w_stepHi = w_sum[SIZE:1];
        w_stepLo = {w_sum[0], r_accLo[SIZE-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_FOR_START;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = WAIT_FOR_START;
        case (r_state)
            WAIT_FOR_START: begin
                w_nextState = bus.start ? CHECK_ZERO : WAIT_FOR_START;
            end
            CHECK_ZERO: begin
                w_nextState = w_zeroOperand ? DONE : ADD_SHIFT;
            end
            ADD_SHIFT: begin
                w_nextState = w_lastStep ? DONE : ADD_SHIFT;
            end
            DONE: begin
                w_nextState = WAIT_FOR_START;
            end
            default: begin
                w_nextState = WAIT_FOR_START;
            end
        endcase
    end

    // The product register is only written on the edge that enters DONE,
    // so it holds the previous result throughout a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_multiplicand <= '0;
            r_multiplier   <= '0;
            r_accHi        <= '0;
            r_accLo        <= '0;
            r_count        <= '0;
            r_product      <= '0;
        end else begin
            case (r_state)
                WAIT_FOR_START: begin
                    if (bus.start) begin
                        r_multiplicand <= bus.multiplicand;
                        r_multiplier   <= bus.multiplier;
                    end
                end
                CHECK_ZERO: begin
                    r_accHi <= '0;
                    if (w_zeroOperand) begin
                        r_accLo   <= '0;
                        r_product <= '0;
                    end else begin
                        r_accLo <= r_multiplier;
                        r_count <= CNT_INIT;
                    end
                end
                ADD_SHIFT: begin
                    r_accHi <= w_stepHi;
                    r_accLo <= w_stepLo;
                    r_count <= r_count - CNT_ONE;
                    if (w_lastStep) begin
                        r_product <= {w_stepHi, w_stepLo};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != WAIT_FOR_START);
    assign bus.done    = (r_state == DONE);
    assign bus.product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed corner cases plus random
// operands compared against plain a*b and the documented cycle latency.
module tb_shift_add_multiplier;

    localparam int SIZE = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [2*SIZE-1:0] lastProduct;

    shift_add_multiplier_if #(.SIZE(SIZE)) bus ();

    shift_add_multiplier #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Runs one multiply. pokeCycle re-asserts start (with 7*7) for one cycle mid-run;
    // resetCycle asserts reset during that cycle to abort the run. 0 disables either.
    task automatic applyStimulus(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                 input int pokeCycle, input int resetCycle);
        logic [2*SIZE-1:0] expProd;
        int lat;
        bit aborted;
        expProd = (2*SIZE)'(a) * (2*SIZE)'(b);
        lat     = (a == 0 || b == 0) ? 2 : SIZE + 2;
        aborted = 1'b0;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.start        = 1'b0;
                bus.multiplicand = SIZE'($urandom);
                bus.multiplier   = SIZE'($urandom);
            end
            if (pokeCycle != 0 && cyc == pokeCycle + 1) bus.start = 1'b0;
            if (reset) reset = 1'b0;
            if (aborted) begin
                checkOutput("abortBusy", bus.busy, 0);
                checkOutput("abortDone", bus.done, 0);
                checkOutput("abortProduct", bus.product, 0);
            end else if (cyc < lat) begin
                checkOutput("runBusy", bus.busy, 1);
                checkOutput("runDoneEarly", bus.done, 0);
                checkOutput("runProductHold", bus.product, lastProduct);
            end else if (cyc == lat) begin
                checkOutput("doneAtLatency", bus.done, 1);
                checkOutput("doneBusy", bus.busy, 1);
                checkOutput("product", bus.product, expProd);
                lastProduct = expProd;
            end else begin
                checkOutput("idleDone", bus.done, 0);
                checkOutput("idleBusy", bus.busy, 0);
                checkOutput("idleProduct", bus.product, lastProduct);
            end
            if (cyc == pokeCycle) begin
                bus.start        = 1'b1;
                bus.multiplicand = 7;
                bus.multiplier   = 7;
            end
            if (cyc == resetCycle) begin
                reset       = 1'b1;
                aborted     = 1'b1;
                lastProduct = '0;
            end
        end
    endtask

    // Start held high across two runs: second accept happens the cycle after DONE.
    task automatic applyHeldStart();
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 13;
        bus.multiplier   = 11;
        for (int cyc = 1; cyc <= SIZE + 2; cyc++) begin
            @(negedge clk);
            checkOutput("heldBusy", bus.busy, 1);
            checkOutput("heldDone", bus.done, (cyc == SIZE + 2) ? 1 : 0);
            if (cyc == SIZE + 2) begin
                checkOutput("heldProduct1", bus.product, 143);
                bus.multiplicand = 6;
                bus.multiplier   = 9;
            end
        end
        @(negedge clk);
        checkOutput("heldGapBusy", bus.busy, 0);
        checkOutput("heldGapProduct", bus.product, 143);
        @(negedge clk);
        checkOutput("heldReaccept", bus.busy, 1);
        bus.start        = 1'b0;
        bus.multiplicand = SIZE'($urandom);
        bus.multiplier   = SIZE'($urandom);
        for (int cyc = 2; cyc <= SIZE + 2; cyc++) begin
            @(negedge clk);
            checkOutput("held2Done", bus.done, (cyc == SIZE + 2) ? 1 : 0);
            checkOutput("held2Product", bus.product, (cyc == SIZE + 2) ? 54 : 143);
        end
        lastProduct = 54;
        @(negedge clk);
        checkOutput("held2Idle", bus.busy, 0);
    endtask

    initial begin
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;
        checks           = 0;
        errors           = 0;
        lastProduct      = '0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetBusy", bus.busy, 0);
        checkOutput("resetDone", bus.done, 0);
        checkOutput("resetProduct", bus.product, 0);

        applyStimulus(8'd13, 8'd11, 0, 0);
        applyStimulus(8'd0, 8'd200, 0, 0);
        applyStimulus(8'd200, 8'd0, 2, 0);
        applyStimulus(8'd255, 8'd255, 0, 0);
        applyStimulus(8'd1, 8'd128, 0, 0);
        applyStimulus(8'd128, 8'd2, 0, 0);
        applyStimulus(8'd13, 8'd11, 4, 0);
        applyStimulus(8'd3, 8'd5, SIZE + 2, 0);
        applyHeldStart();
        applyStimulus(8'd255, 8'd255, 0, 5);
        applyStimulus(8'd6, 8'd7, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = SIZE'($urandom);
            rb = SIZE'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            applyStimulus(ra, rb, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
